// File: rtl/i4_neighbour_ctx.sv
// Sub-block sequencer and neighbour-context buffer for 4x4 intra prediction over one macroblock.
// Presents left/top-left/top/top-right pixels per sub-block and absorbs each reconstruction.
module i4_neighbour_ctx #(
    parameter int unsigned PIX_W = 8,
    parameter int unsigned N     = 4,
    localparam int unsigned W     = 4 * N,
    localparam int unsigned IDX_W = $clog2(N * N)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [PIX_W-1:0]         mb_top_left,
    input  logic [PIX_W*(W+4)-1:0]   mb_top,
    input  logic [PIX_W*W-1:0]       mb_left,
    output logic                     nb_valid,
    input  logic                     nb_ready,
    output logic [IDX_W-1:0]         nb_idx,
    output logic [4*PIX_W-1:0]       nb_left,
    output logic [PIX_W-1:0]         nb_top_left,
    output logic [4*PIX_W-1:0]       nb_top,
    output logic [4*PIX_W-1:0]       nb_top_right,
    input  logic                     rec_valid,
    output logic                     rec_ready,
    input  logic [16*PIX_W-1:0]      rec_blk,
    output logic                     busy,
    output logic                     done
);

    localparam int unsigned TW   = W + 4;
    localparam int unsigned RC_W = $clog2(N);
    localparam int unsigned TA_W = $clog2(TW);
    localparam int unsigned LA_W = $clog2(W);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EMIT,
        S_WAIT_REC,
        S_DONE
    } state_t;

    state_t state;

    logic [PIX_W-1:0] tbuf   [TW];
    logic [PIX_W-1:0] tbuf_d [TW];
    logic [PIX_W-1:0] lbuf   [W];
    logic [PIX_W-1:0] lbuf_d [W];
    logic [PIX_W-1:0] rcol   [4];
    logic [PIX_W-1:0] rcol_d [4];
    logic [PIX_W-1:0] corner, corner_d;
    logic [RC_W-1:0]  row, row_d, col, col_d;
    logic [IDX_W-1:0] idx, idx_d;

    logic [4*PIX_W-1:0] nb_left_d, nb_top_d, nb_top_right_d;

    logic        load, accept, last;
    int unsigned c_i, r_i, cn, rn;

    assign load   = (state == S_IDLE) && start;
    assign accept = (state == S_WAIT_REC) && rec_valid;
    assign last   = (idx == IDX_W'(N * N - 1));
    assign nb_idx = idx;

    // Interior recon pixels never become neighbour context.
    logic unused_rec;
    assign unused_rec = ^rec_blk;

    // Next context and the bundle for the sub-block that will be current after this edge.
    always_comb begin
        tbuf_d         = tbuf;
        lbuf_d         = lbuf;
        rcol_d         = rcol;
        corner_d       = corner;
        row_d          = row;
        col_d          = col;
        idx_d          = idx;
        nb_left_d      = '0;
        nb_top_d       = '0;
        nb_top_right_d = '0;
        c_i            = 32'(col);
        r_i            = 32'(row);

        if (load) begin
            for (int k = 0; k < int'(TW); k++) begin
                tbuf_d[k] = mb_top[k*PIX_W +: PIX_W];
            end
            for (int k = 0; k < int'(W); k++) begin
                lbuf_d[k] = mb_left[k*PIX_W +: PIX_W];
            end
            corner_d = mb_top_left;
            row_d    = '0;
            col_d    = '0;
            idx_d    = '0;
        end else if (accept) begin
            for (int k = 0; k < 4; k++) begin
                tbuf_d[TA_W'(4 * c_i + 32'(k))] = rec_blk[(12 + k)*PIX_W +: PIX_W];
                rcol_d[k]                       = rec_blk[(4 * k + 3)*PIX_W +: PIX_W];
            end
            // Corner for the next block is the pixel above-right of this one, or the left column at a row wrap.
            corner_d = (col == RC_W'(N - 1)) ? lbuf[LA_W'(4 * r_i + 3)]
                                             : tbuf[TA_W'(4 * c_i + 3)];
            if (!last) begin
                idx_d = idx + IDX_W'(1);
                if (col == RC_W'(N - 1)) begin
                    col_d = '0;
                    row_d = row + RC_W'(1);
                end else begin
                    col_d = col + RC_W'(1);
                end
            end
        end

        cn = 32'(col_d);
        rn = 32'(row_d);
        for (int k = 0; k < 4; k++) begin
            nb_top_d[k*PIX_W +: PIX_W]       = tbuf_d[TA_W'(4 * cn + 32'(k))];
            nb_top_right_d[k*PIX_W +: PIX_W] = tbuf_d[TA_W'(4 * cn + 4 + 32'(k))];
            nb_left_d[k*PIX_W +: PIX_W]      = (col_d == '0) ? lbuf_d[LA_W'(4 * rn + 32'(k))]
                                                             : rcol_d[k];
        end
    end

    // Sequencer, context registers and registered bundle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            nb_valid     <= 1'b0;
            rec_ready    <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            for (int k = 0; k < int'(TW); k++) begin
                tbuf[k] <= '0;
            end
            for (int k = 0; k < int'(W); k++) begin
                lbuf[k] <= '0;
            end
            for (int k = 0; k < 4; k++) begin
                rcol[k] <= '0;
            end
            corner       <= '0;
            row          <= '0;
            col          <= '0;
            idx          <= '0;
            nb_left      <= '0;
            nb_top       <= '0;
            nb_top_right <= '0;
            nb_top_left  <= '0;
        end else begin
            tbuf         <= tbuf_d;
            lbuf         <= lbuf_d;
            rcol         <= rcol_d;
            corner       <= corner_d;
            row          <= row_d;
            col          <= col_d;
            idx          <= idx_d;
            nb_left      <= nb_left_d;
            nb_top       <= nb_top_d;
            nb_top_right <= nb_top_right_d;
            nb_top_left  <= corner_d;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_EMIT;
                        nb_valid <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                S_EMIT: begin
                    if (nb_ready) begin
                        state     <= S_WAIT_REC;
                        nb_valid  <= 1'b0;
                        rec_ready <= 1'b1;
                    end
                end
                S_WAIT_REC: begin
                    if (rec_valid) begin
                        rec_ready <= 1'b0;
                        if (last) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state    <= S_EMIT;
                            nb_valid <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
